sseg_scan_capture: RTL and testbench
====================================

Name: sseg_scan_capture

Overview:
Passive monitor that samples the multiplexed 4-digit 7-segment bus (active-low anodes and segments), waits for it to settle, and decodes each segment pattern back to a hex nibble. It assembles one frame per full anode scan and publishes it. It is the read side of the display drivers, used for self-check and for loopback on the board. It never drives the display.

Parameters:
SETTLE_CYCLES, 4, number of consecutive identical samples required before a digit is captured (legal range 1..255)
TIMEOUT_W, 24, width of the inactivity watchdog; stale is flagged after 2^TIMEOUT_W-1 cycles with no capture

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
an  in  4  anode bus, active-low; digit i is selected when only bit i is 0
sseg  in  8  segment bus, active-low, {dp,g,f,e,d,c,b,a}
digits  out  16  published frame; digit i occupies bits [4i+3:4i]
dp  out  4  decimal point per digit, active-high (on)
code_ok  out  4  per digit, 1 = segment pattern is a legal hex glyph
frame_done  out  1  one-cycle pulse when a new frame is published
changed  out  1  one-cycle pulse, coincident with frame_done, when {digits,dp,code_ok} differs from the previous frame
stale  out  1  no capture for 2^TIMEOUT_W-1 cycles
order_err  out  1  sticky scan-order error (see Optional Feature)

Behaviour:
- Reset values:
  - digits=0, dp=0, code_ok=0, frame_done=0, changed=0, stale=0, order_err=0.
  - Sample register = {an=4'hF, sseg=8'hFF}; stability count=0; seen mask=0; shadow=0; watchdog=0.
- Sampling, on every edge:
  - If {an,sseg} equals the sample register, the count increments and saturates at SETTLE_CYCLES. Otherwise the count is set to 0.
  - The sample register always loads {an,sseg}.
- Capture:
  - Occurs on the edge where the count goes from SETTLE_CYCLES-1 to SETTLE_CYCLES and the sampled an has exactly one 0 bit.
  - A pattern that is stable from before edge 1 is therefore captured on edge SETTLE_CYCLES+1.
  - At most one capture per stable interval.
  - an=1111, an=0000, or more than one 0 bit: no capture, and the watchdog is not cleared.
- Decode, on sseg[6:0]:
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F.
  - Legal pattern: nibble as listed, code_ok=1.
  - Any other pattern (including blank 7F): nibble=0, code_ok=0.
  - dp bit = ~sseg[7].
- Capture writes the shadow slot i and sets seen[i]. Recapturing a slot before the frame completes overwrites it.
- Frame publish:
  - Triggered on the edge after the capture that makes seen=1111.
  - That edge loads digits/dp/code_ok from the shadow, pulses frame_done for 1 cycle, pulses changed if the published value differs from the prior one, and clears seen.
  - The first frame after reset always pulses changed.
  - A capture on the publish edge is kept in the shadow, and its seen bit is set for the next frame.
- Watchdog:
  - Increments each cycle and is cleared on any capture.
  - On reaching all-ones it sets stale and holds.
  - stale clears on the next frame_done.
  - A capture on the same edge the watchdog would reach all-ones wins: stale is not set.
  - Published outputs hold their last values while stale.
- Reset mid-frame discards the shadow and seen. Four fresh captures are required before the next frame_done.

Optional Feature:
SSEG_CAP_ORDER_CHECK_EN:
- Defined: each capture must target slot (previous captured slot + 1) mod 4, matching a rotate-left scan 1110→1101→1011→0111. A violation sets order_err, which stays set until reset. The first capture after reset is exempt. Frame assembly is unaffected.
- Undefined: order_err is tied to 0 and no order logic is built.

Test Plan:
1. Default parameters; drive an 1110/1101/1011/0111 with sseg C0/F9/A4/B0, each held 10 cycles → one frame_done; digits=16'h3210, code_ok=1111, dp=0000, changed=1.
2. Repeat the identical scan → frame_done=1, changed=0. Next scan with digit 2 sseg=0x24 (dp on) → changed=1, dp=0100.
3. Hold a pattern for exactly SETTLE_CYCLES cycles then change it → no capture. Hold for SETTLE_CYCLES+1 → captured on edge 5.
4. Hold an=1100 and an=1111 for 50 cycles each → no capture, seen unchanged. Hold an=1110 with sseg=FF → slot 0 captured, nibble 0, code_ok[0]=0.
5. TIMEOUT_W=8; no legal capture for 255 cycles → stale=1 and digits retained. Next complete scan → stale=0 on frame_done.
6. Reset after 2 captures, then a full scan → exactly one frame_done. With SSEG_CAP_ORDER_CHECK_EN, scan order 0,2,1,3 → order_err=1, remains 1 until reset.

Source files
------------

// File: rtl/sseg_scan_capture.sv
// Passive read-back monitor for a multiplexed 4-digit active-low 7-segment bus.
// Optional scan-order checker is built only when SSEG_CAP_ORDER_CHECK_EN is defined.
module sseg_scan_capture #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned TIMEOUT_W     = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [7:0]  sseg,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  code_ok,
    output logic        frame_done,
    output logic        changed,
    output logic        stale,
    output logic        order_err
);

    localparam logic [7:0]           SETTLE = 8'(SETTLE_CYCLES);
    localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

    logic [11:0]          samp_q, samp_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [15:0]          sh_dig_q, sh_dig_d;
    logic [3:0]           sh_dp_q, sh_dp_d;
    logic [3:0]           sh_ok_q, sh_ok_d;
    logic [3:0]           seen_q, seen_d;
    logic [15:0]          digits_q, digits_d;
    logic [3:0]           dp_q, dp_d;
    logic [3:0]           code_ok_q, code_ok_d;
    logic                 frame_done_q, frame_done_d;
    logic                 changed_q, changed_d;
    logic                 first_q, first_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic                 stale_q, stale_d;

    logic                 match;
    logic                 slot_vld;
    logic [1:0]           slot;
    logic                 cap;
    logic                 publish;
    logic [3:0]           nib;
    logic                 ok;

    always_comb begin
        slot     = 2'd0;
        slot_vld = 1'b0;
        case (an)
            4'b1110: begin slot = 2'd0; slot_vld = 1'b1; end
            4'b1101: begin slot = 2'd1; slot_vld = 1'b1; end
            4'b1011: begin slot = 2'd2; slot_vld = 1'b1; end
            4'b0111: begin slot = 2'd3; slot_vld = 1'b1; end
            default: begin slot = 2'd0; slot_vld = 1'b0; end
        endcase
    end

    always_comb begin
        nib = 4'h0;
        ok  = 1'b1;
        case (sseg[6:0])
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h10: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            default: begin nib = 4'h0; ok = 1'b0; end
        endcase
    end

    always_comb begin
        samp_d = {an, sseg};
        match  = ({an, sseg} == samp_q);
        cnt_d  = 8'd0;
        if (match) begin
            cnt_d = (cnt_q == SETTLE) ? SETTLE : cnt_q + 8'd1;
        end
        // Exactly one capture per stable interval: only the step into SETTLE counts.
        cap     = match && (cnt_q == SETTLE - 8'd1) && slot_vld;
        publish = (seen_q == 4'hF);

        sh_dig_d = sh_dig_q;
        sh_dp_d  = sh_dp_q;
        sh_ok_d  = sh_ok_q;
        seen_d   = publish ? 4'h0 : seen_q;
        if (cap) begin
            sh_dig_d[{slot, 2'b00} +: 4] = nib;
            sh_dp_d[slot]                = ~sseg[7];
            sh_ok_d[slot]                = ok;
            seen_d[slot]                 = 1'b1;
        end

        digits_d     = digits_q;
        dp_d         = dp_q;
        code_ok_d    = code_ok_q;
        frame_done_d = publish;
        changed_d    = 1'b0;
        first_d      = first_q;
        if (publish) begin
            digits_d  = sh_dig_q;
            dp_d      = sh_dp_q;
            code_ok_d = sh_ok_q;
            changed_d = first_q || ({sh_dig_q, sh_dp_q, sh_ok_q} != {digits_q, dp_q, code_ok_q});
            first_d   = 1'b0;
        end

        if (cap) begin
            wd_d = '0;
        end else if (wd_q == WD_MAX) begin
            wd_d = wd_q;
        end else begin
            wd_d = wd_q + 1'b1;
        end

        stale_d = stale_q;
        if (publish) begin
            stale_d = 1'b0;
        end else if (wd_d == WD_MAX) begin
            stale_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            samp_q       <= 12'hFFF;
            cnt_q        <= 8'd0;
            sh_dig_q     <= 16'h0;
            sh_dp_q      <= 4'h0;
            sh_ok_q      <= 4'h0;
            seen_q       <= 4'h0;
            digits_q     <= 16'h0;
            dp_q         <= 4'h0;
            code_ok_q    <= 4'h0;
            frame_done_q <= 1'b0;
            changed_q    <= 1'b0;
            first_q      <= 1'b1;
            wd_q         <= '0;
            stale_q      <= 1'b0;
        end else begin
            samp_q       <= samp_d;
            cnt_q        <= cnt_d;
            sh_dig_q     <= sh_dig_d;
            sh_dp_q      <= sh_dp_d;
            sh_ok_q      <= sh_ok_d;
            seen_q       <= seen_d;
            digits_q     <= digits_d;
            dp_q         <= dp_d;
            code_ok_q    <= code_ok_d;
            frame_done_q <= frame_done_d;
            changed_q    <= changed_d;
            first_q      <= first_d;
            wd_q         <= wd_d;
            stale_q      <= stale_d;
        end
    end

    assign digits     = digits_q;
    assign dp         = dp_q;
    assign code_ok    = code_ok_q;
    assign frame_done = frame_done_q;
    assign changed    = changed_q;
    assign stale      = stale_q;

`ifdef SSEG_CAP_ORDER_CHECK_EN
    logic [1:0] last_slot_q, last_slot_d;
    logic [1:0] next_slot;
    logic       have_last_q, have_last_d;
    logic       order_err_q, order_err_d;

    // Expected scan is rotate-left on the anodes, i.e. slot index ascending mod 4.
    always_comb begin
        next_slot   = last_slot_q + 2'd1;
        last_slot_d = last_slot_q;
        have_last_d = have_last_q;
        order_err_d = order_err_q;
        if (cap) begin
            if (have_last_q && (slot != next_slot)) begin
                order_err_d = 1'b1;
            end
            last_slot_d = slot;
            have_last_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_slot_q <= 2'd0;
            have_last_q <= 1'b0;
            order_err_q <= 1'b0;
        end else begin
            last_slot_q <= last_slot_d;
            have_last_q <= have_last_d;
            order_err_q <= order_err_d;
        end
    end

    assign order_err = order_err_q;
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Directed bench for sseg_scan_capture: table of full scans plus hand-written corner sequences.
module tb_sseg_scan_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  code_ok;
    logic        frame_done;
    logic        changed;
    logic        stale;
    logic        order_err;

`ifdef SSEG_CAP_ORDER_CHECK_EN
    localparam logic ORD_EN = 1'b1;
`else
    localparam logic ORD_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    sseg_scan_capture #(.SETTLE_CYCLES(4), .TIMEOUT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .an         (an),
        .sseg       (sseg),
        .digits     (digits),
        .dp         (dp),
        .code_ok    (code_ok),
        .frame_done (frame_done),
        .changed    (changed),
        .stale      (stale),
        .order_err  (order_err)
    );

    int   errors = 0;
    int   checks = 0;
    int   fd_cnt = 0;
    int   fd0;
    logic chg_at_fd = 1'b0;
    logic stale_at_fd = 1'b0;

    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            fd_cnt++;
            chg_at_fd   = changed;
            stale_at_fd = stale;
        end
    end

    typedef struct {
        logic [31:0] segs;     // {s3,s2,s1,s0}
        logic [15:0] exp_dig;
        logic [3:0]  exp_dp;
        logic [3:0]  exp_ok;
        logic        exp_chg;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
        an   = a;
        sseg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan4(input logic [31:0] s);
        hold(4'hE, s[7:0],   10);
        hold(4'hD, s[15:8],  10);
        hold(4'hB, s[23:16], 10);
        hold(4'h7, s[31:24], 10);
    endtask

    task automatic do_reset();
        an    = 4'hF;
        sseg  = 8'hFF;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'hB0A4F9C0, 16'h3210, 4'b0000, 4'b1111, 1'b1};
        vecs[1] = '{32'hB0A4F9C0, 16'h3210, 4'b0000, 4'b1111, 1'b0};
        vecs[2] = '{32'hB024F9C0, 16'h3210, 4'b0100, 4'b1111, 1'b1};
        vecs[3] = '{32'hF8829299, 16'h7654, 4'b0000, 4'b1111, 1'b1};
        vecs[4] = '{32'h83889080, 16'hBA98, 4'b0000, 4'b1111, 1'b1};
        vecs[5] = '{32'h8E86A1C6, 16'hFEDC, 4'b0000, 4'b1111, 1'b1};
        vecs[6] = '{32'hA4C07FFF, 16'h2000, 4'b0010, 4'b1100, 1'b1};
        vecs[7] = '{32'hB0A4F955, 16'h3210, 4'b0001, 4'b1110, 1'b1};

        do_reset();
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_dp", 32'(dp), 32'h0);
        chk("rst_code_ok", 32'(code_ok), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        chk("rst_changed", 32'(changed), 32'h0);
        chk("rst_stale", 32'(stale), 32'h0);
        chk("rst_order_err", 32'(order_err), 32'h0);

        for (int i = 0; i < 8; i++) begin
            fd0 = fd_cnt;
            scan4(vecs[i].segs);
            chk($sformatf("v%0d_frames", i), 32'(fd_cnt - fd0), 32'd1);
            chk($sformatf("v%0d_digits", i), 32'(digits), 32'(vecs[i].exp_dig));
            chk($sformatf("v%0d_dp", i), 32'(dp), 32'(vecs[i].exp_dp));
            chk($sformatf("v%0d_code_ok", i), 32'(code_ok), 32'(vecs[i].exp_ok));
            chk($sformatf("v%0d_changed", i), 32'(chg_at_fd), 32'(vecs[i].exp_chg));
        end
        chk("pulse_one_cycle", 32'(frame_done), 32'h0);
        chk("table_order_err", 32'(order_err), 32'h0);

        do_reset();
        chk("rst2_digits", 32'(digits), 32'h0);
        chk("rst2_dp", 32'(dp), 32'h0);
        chk("rst2_code_ok", 32'(code_ok), 32'h0);

        // settle boundary: 4 stable edges is too short, 5 captures on edge 5
        fd0 = fd_cnt;
        hold(4'hE, 8'hC0, 4);
        hold(4'hF, 8'hFF, 10);
        hold(4'hD, 8'hF9, 10);
        hold(4'hB, 8'hA4, 10);
        hold(4'h7, 8'hB0, 10);
        chk("settle_short_no_cap", 32'(fd_cnt - fd0), 32'd0);
        hold(4'hE, 8'hC0, 5);
        hold(4'hF, 8'hFF, 1);
        chk("settle_edge5_publish", 32'(frame_done), 32'h1);
        chk("settle_digits", 32'(digits), 32'h3210);
        chk("settle_changed_first", 32'(changed), 32'h1);

        // invalid anode patterns never capture
        do_reset();
        fd0 = fd_cnt;
        hold(4'hE, 8'hC0, 10);
        hold(4'hD, 8'hF9, 10);
        hold(4'hC, 8'h99, 50);
        hold(4'hF, 8'h99, 50);
        hold(4'h0, 8'h99, 20);
        hold(4'hA, 8'h99, 20);
        chk("bad_an_no_frame", 32'(fd_cnt - fd0), 32'd0);
        hold(4'hB, 8'hA4, 10);
        hold(4'h7, 8'hB0, 10);
        chk("bad_an_frames", 32'(fd_cnt - fd0), 32'd1);
        chk("bad_an_digits", 32'(digits), 32'h3210);
        chk("bad_an_code_ok", 32'(code_ok), 32'hF);

        // reset mid-frame discards shadow and seen
        do_reset();
        hold(4'hB, 8'h80, 10);
        hold(4'h7, 8'h90, 10);
        do_reset();
        fd0 = fd_cnt;
        hold(4'hE, 8'h99, 10);
        hold(4'hD, 8'h92, 10);
        hold(4'hF, 8'hFF, 10);
        chk("rst_mid_no_frame", 32'(fd_cnt - fd0), 32'd0);
        hold(4'hB, 8'h82, 10);
        hold(4'h7, 8'hF8, 10);
        chk("rst_mid_frames", 32'(fd_cnt - fd0), 32'd1);
        chk("rst_mid_digits", 32'(digits), 32'h7654);

        // watchdog: capture on the would-be terminal edge wins, then exact limit
        do_reset();
        hold(4'hC, 8'h99, 250);
        hold(4'hE, 8'hC0, 5);
        chk("cap_beats_stale", 32'(stale), 32'h0);
        hold(4'hC, 8'h99, 254);
        chk("stale_before_limit", 32'(stale), 32'h0);
        hold(4'hC, 8'h99, 1);
        chk("stale_at_limit", 32'(stale), 32'h1);
        fd0 = fd_cnt;
        hold(4'hD, 8'hF9, 10);
        hold(4'hB, 8'hA4, 10);
        hold(4'h7, 8'hB0, 10);
        chk("stale_frames", 32'(fd_cnt - fd0), 32'd1);
        chk("stale_clr_at_fd", 32'(stale_at_fd), 32'h0);
        chk("stale_clr_digits", 32'(digits), 32'h3210);
        fd0 = fd_cnt;
        hold(4'hF, 8'hFF, 300);
        chk("stale_idle", 32'(stale), 32'h1);
        chk("stale_hold_digits", 32'(digits), 32'h3210);
        chk("stale_hold_ok", 32'(code_ok), 32'hF);
        chk("stale_no_frame", 32'(fd_cnt - fd0), 32'd0);

        // recapture overwrites a slot (also an order violation when checking is built)
        do_reset();
        fd0 = fd_cnt;
        hold(4'hE, 8'hC0, 10);
        hold(4'hE, 8'hF9, 10);
        hold(4'hD, 8'hF9, 10);
        hold(4'hB, 8'hA4, 10);
        hold(4'h7, 8'hB0, 10);
        chk("recap_frames", 32'(fd_cnt - fd0), 32'd1);
        chk("recap_digits", 32'(digits), 32'h3211);
        chk("recap_order_err", 32'(order_err), 32'(ORD_EN));
        scan4(32'hB0A4F9C0);
        chk("order_err_sticky", 32'(order_err), 32'(ORD_EN));

        do_reset();
        chk("order_err_rst", 32'(order_err), 32'h0);
        fd0 = fd_cnt;
        hold(4'hE, 8'hC0, 10);
        hold(4'hB, 8'hA4, 10);
        hold(4'hD, 8'hF9, 10);
        hold(4'h7, 8'hB0, 10);
        chk("ooo_frames", 32'(fd_cnt - fd0), 32'd1);
        chk("ooo_digits", 32'(digits), 32'h3210);
        chk("ooo_order_err", 32'(order_err), 32'(ORD_EN));
        scan4(32'hB0A4F9C0);
        chk("ooo_order_sticky", 32'(order_err), 32'(ORD_EN));
        do_reset();
        chk("ooo_order_rst", 32'(order_err), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
